// File: rtl/apb_req_arb_pkg.sv
// apb_req_arb_pkg: shared state type, default sizes and small helpers for
// the APB request arbiter and its round-robin picker.
package apb_req_arb_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREQ_DEF  = 4;
  localparam int TOUT_DEF  = 256;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  // Index that follows idx in a ring of n requesters.
  function automatic int nextIdx(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/apb_req_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker. Given the pending request
// vector and the current priority pointer, returns a one-hot winner. The
// pointer register itself lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         winner_o
);

  localparam int PW = $clog2(NREQ);

  logic          found;
  logic [PW-1:0] idx;

  // Scan upward from the pointer, wrapping past NREQ-1, keeping the first hit.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = PW'((int'(ptr_i) + off) % NREQ);
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        winner_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arb.sv
// apb_req_arb: round-robin scheduler sharing one APB master bridge between
// NREQ requesters. One transfer at a time: IDLE -> ISSUE -> WAIT -> DONE.
// Optional feature macro: APB_ARB_TIMEOUT_EN adds a WAIT-state timeout of
// TOUT cycles that completes the transfer with req_err=1 and zero read data.
module apb_req_arb
  import apb_req_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int TOUT  = TOUT_DEF
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_write,
  input  logic [NREQ*WIDTH-1:0]   req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_wdata,
  input  logic [NREQ*4-1:0]       req_sel,
  output logic [NREQ-1:0]         req_ack,
  output logic [WIDTH-1:0]        req_rdata,
  output logic                    req_err,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic [WIDTH-1:0]        p_addr,
  output logic [WIDTH-1:0]        pw_data,
  output logic [3:0]              p_sel,
  output logic                    p_wr,
  output logic                    trans,
  input  logic                    m_pready,
  input  logic [WIDTH-1:0]        m_prdata
);

  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TOUT < 2) begin : gParamCheck
    $error("apb_req_arb: NREQ must be 2..8 and TOUT at least 2");
  end

  arb_state_t       state_q;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  winner;
  logic [NREQ-1:0]  grant_q, ack_q;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q;
  logic [3:0]       sel_q, sel_d;
  logic             wr_q, wr_d;
  logic             trans_q, busy_q;
  logic             firstWait;
  logic             expire;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TOUT + 1);
  logic [CW-1:0] waitCnt_q;
  logic          err_q;
  assign firstWait = (waitCnt_q == '0);
  assign expire    = (waitCnt_q == CW'(TOUT - 1));
  assign req_err   = err_q;
`else
  logic firstWait_q;
  assign firstWait = firstWait_q;
  assign expire    = 1'b0;
  assign req_err   = 1'b0;
`endif

  rr_arbiter #(.NREQ(NREQ)) uArb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .winner_o (winner)
  );

  // Select the winning requester's command slice and the pointer after it.
  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    sel_d   = '0;
    wr_d    = 1'b0;
    ptr_d   = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) begin
        addr_d  = req_addr[i*WIDTH +: WIDTH];
        wdata_d = req_wdata[i*WIDTH +: WIDTH];
        sel_d   = req_sel[i*4 +: 4];
        wr_d    = req_write[i];
        ptr_d   = PW'(nextIdx(i, NREQ));
      end
    end
  end

  // Transfer sequencer; every bridge and requester output is registered here.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      wr_q        <= 1'b0;
      trans_q     <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      waitCnt_q   <= '0;
      err_q       <= 1'b0;
`else
      firstWait_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_q <= winner;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            ptr_q   <= ptr_d;
            trans_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          trans_q     <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
          waitCnt_q   <= '0;
`else
          firstWait_q <= 1'b1;
`endif
          state_q     <= WAIT;
        end
        WAIT: begin
          if (!firstWait && m_pready) begin
            if (!wr_q) begin
              rdata_q <= m_prdata;
            end
            ack_q   <= grant_q;
            state_q <= DONE;
          end else if (expire) begin
            rdata_q <= '0;
            ack_q   <= grant_q;
`ifdef APB_ARB_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
            state_q <= DONE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          waitCnt_q   <= waitCnt_q + 1'b1;
`else
          firstWait_q <= 1'b0;
`endif
        end
        DONE: begin
          ack_q   <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack   = ack_q;
  assign req_rdata = rdata_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign p_addr    = addr_q;
  assign pw_data   = wdata_q;
  assign p_sel     = sel_q;
  assign p_wr      = wr_q;
  assign trans     = trans_q;

endmodule
